// File: rtl/sync_timing_gen.sv
// sync_timing_gen: one-axis video timing generator (pixels or lines).
// A wrapping position counter plus a phase register (ACTIVE/FRONT/SYNC/BACK).
// Every output except o_wrap is registered and updated together with the counter.
// Zero-length porches are skipped, so their phase never appears.
module sync_timing_gen #(
    parameter int unsigned ACTIVE      = 272,
    parameter int unsigned FRONT_PORCH = 4,
    parameter int unsigned SYNC_LEN    = 10,
    parameter int unsigned BACK_PORCH  = 4,
    parameter bit          SYNC_POL    = 1'b0,
    parameter int unsigned CNT_W       = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0] o_pos,
    output logic             o_de,
    output logic             o_sync,
    output logic             o_first,
    output logic             o_last,
    output logic             o_wrap,
    output logic [1:0]       o_phase
);

    localparam int unsigned       TOTAL    = ACTIVE + FRONT_PORCH + SYNC_LEN + BACK_PORCH;
    localparam longint unsigned   CAPACITY = 64'd1 << CNT_W;

    // Reject geometries that cannot be counted correctly.
    if (ACTIVE == 0) begin : g_bad_active
        $error("sync_timing_gen: ACTIVE must be at least 1");
    end
    if (SYNC_LEN == 0) begin : g_bad_sync
        $error("sync_timing_gen: SYNC_LEN must be at least 1");
    end
    if (longint'(TOTAL) > longint'(CAPACITY)) begin : g_bad_width
        $error("sync_timing_gen: TOTAL does not fit in CNT_W bits");
    end

    // Phase boundary positions, sized to the counter.
    localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_C       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] LAST_ACT_C   = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] FRONT_C      = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_C       = CNT_W'(ACTIVE + FRONT_PORCH);
    // With no back porch this boundary equals TOTAL (may not fit), and is never used.
    localparam logic [CNT_W-1:0] BACK_C       = (BACK_PORCH > 0) ?
                                                CNT_W'(ACTIVE + FRONT_PORCH + SYNC_LEN) : '0;
    localparam logic             SYNC_ON      = SYNC_POL;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    phase_t           phase;
    phase_t           phase_nxt;
    logic             at_last;

    assign at_last = (cnt == LAST_C);

    // Next counter value and the phase that position belongs to.
    always_comb begin
        cnt_nxt   = cnt + ONE_C;
        phase_nxt = phase;
        if (at_last) begin
            cnt_nxt   = '0;
            phase_nxt = PH_ACTIVE;
        end else if (cnt_nxt == FRONT_C) begin
            phase_nxt = (FRONT_PORCH > 0) ? PH_FRONT : PH_SYNC;
        end else if ((FRONT_PORCH > 0) && (cnt_nxt == SYNC_C)) begin
            phase_nxt = PH_SYNC;
        end else if ((BACK_PORCH > 0) && (cnt_nxt == BACK_C)) begin
            phase_nxt = PH_BACK;
        end
    end

    // Counter, phase and registered decodes, stepping only when enabled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt     <= '0;
            phase   <= PH_ACTIVE;
            o_de    <= 1'b1;
            o_pos   <= '0;
            o_first <= 1'b1;
            o_last  <= (ACTIVE == 1);
            o_sync  <= ~SYNC_ON;
        end else if (i_en) begin
            cnt     <= cnt_nxt;
            phase   <= phase_nxt;
            o_de    <= (phase_nxt == PH_ACTIVE);
            o_pos   <= (phase_nxt == PH_ACTIVE) ? cnt_nxt : '0;
            o_first <= (cnt_nxt == '0);
            o_last  <= (cnt_nxt == LAST_ACT_C);
            o_sync  <= (phase_nxt == PH_SYNC) ? SYNC_ON : ~SYNC_ON;
        end
    end

    assign o_cnt   = cnt;
    assign o_phase = phase;
    assign o_wrap  = at_last & i_en;

endmodule

// File: tb/tb_sync_timing_gen.sv
// tb_sync_timing_gen: five generator instances driven with random enables and resets.
// Instances: A (4/1/2/1), C (3/0/1/0), H (4/1/2/1) cascaded into V (2/0/1/1), D (defaults, SYNC_POL=1).
// A reference model predicts each cycle's outputs from the timing rules; a monitor compares.
module tb_sync_timing_gen;

    localparam int N_CYC = 1500;
    localparam int NI    = 5;
    localparam int ACT [NI] = '{4, 3, 4, 2, 272};
    localparam int FP  [NI] = '{1, 0, 1, 0, 4};
    localparam int SL  [NI] = '{2, 1, 2, 1, 10};
    localparam int BP  [NI] = '{1, 0, 1, 1, 4};
    localparam int POL [NI] = '{0, 0, 0, 0, 1};

    typedef struct packed {
        logic [15:0] cnt;
        logic [15:0] pos;
        logic        de;
        logic        sync;
        logic        first;
        logic        last;
        logic        wrap;
        logic [1:0]  phase;
    } obs_t;
    typedef obs_t [NI-1:0] obs_set_t;

    logic clk = 1'b0;
    logic [NI-1:0] en_v;
    logic [NI-1:0] rst_v;

    logic [2:0] cnt_a, pos_a;  logic de_a, sync_a, first_a, last_a, wrap_a; logic [1:0] ph_a;
    logic [1:0] cnt_c, pos_c;  logic de_c, sync_c, first_c, last_c, wrap_c; logic [1:0] ph_c;
    logic [2:0] cnt_h, pos_h;  logic de_h, sync_h, first_h, last_h, wrap_h; logic [1:0] ph_h;
    logic [1:0] cnt_v, pos_v;  logic de_v, sync_v, first_v, last_v, wrap_v; logic [1:0] ph_v;
    logic [9:0] cnt_d, pos_d;  logic de_d, sync_d, first_d, last_d, wrap_d; logic [1:0] ph_d;

    obs_set_t act;
    obs_set_t sbq [$];
    int       m_cnt [NI];
    int       checks = 0;
    int       errors = 0;
    string    name [NI] = '{"A", "C", "H", "V", "D"};

    always #5 clk = ~clk;

    sync_timing_gen #(.ACTIVE(4), .FRONT_PORCH(1), .SYNC_LEN(2), .BACK_PORCH(1),
                      .SYNC_POL(1'b0), .CNT_W(3)) u_a (
        .i_clk(clk), .i_rst(rst_v[0]), .i_en(en_v[0]), .o_cnt(cnt_a), .o_pos(pos_a),
        .o_de(de_a), .o_sync(sync_a), .o_first(first_a), .o_last(last_a),
        .o_wrap(wrap_a), .o_phase(ph_a));

    sync_timing_gen #(.ACTIVE(3), .FRONT_PORCH(0), .SYNC_LEN(1), .BACK_PORCH(0),
                      .SYNC_POL(1'b0), .CNT_W(2)) u_c (
        .i_clk(clk), .i_rst(rst_v[1]), .i_en(en_v[1]), .o_cnt(cnt_c), .o_pos(pos_c),
        .o_de(de_c), .o_sync(sync_c), .o_first(first_c), .o_last(last_c),
        .o_wrap(wrap_c), .o_phase(ph_c));

    sync_timing_gen #(.ACTIVE(4), .FRONT_PORCH(1), .SYNC_LEN(2), .BACK_PORCH(1),
                      .SYNC_POL(1'b0), .CNT_W(3)) u_h (
        .i_clk(clk), .i_rst(rst_v[2]), .i_en(en_v[2]), .o_cnt(cnt_h), .o_pos(pos_h),
        .o_de(de_h), .o_sync(sync_h), .o_first(first_h), .o_last(last_h),
        .o_wrap(wrap_h), .o_phase(ph_h));

    sync_timing_gen #(.ACTIVE(2), .FRONT_PORCH(0), .SYNC_LEN(1), .BACK_PORCH(1),
                      .SYNC_POL(1'b0), .CNT_W(2)) u_v (
        .i_clk(clk), .i_rst(rst_v[3]), .i_en(wrap_h), .o_cnt(cnt_v), .o_pos(pos_v),
        .o_de(de_v), .o_sync(sync_v), .o_first(first_v), .o_last(last_v),
        .o_wrap(wrap_v), .o_phase(ph_v));

    sync_timing_gen #(.ACTIVE(272), .FRONT_PORCH(4), .SYNC_LEN(10), .BACK_PORCH(4),
                      .SYNC_POL(1'b1), .CNT_W(10)) u_d (
        .i_clk(clk), .i_rst(rst_v[4]), .i_en(en_v[4]), .o_cnt(cnt_d), .o_pos(pos_d),
        .o_de(de_d), .o_sync(sync_d), .o_first(first_d), .o_last(last_d),
        .o_wrap(wrap_d), .o_phase(ph_d));

    // Gather observed outputs of every instance into one record.
    always_comb begin
        act[0] = '{16'(cnt_a), 16'(pos_a), de_a, sync_a, first_a, last_a, wrap_a, ph_a};
        act[1] = '{16'(cnt_c), 16'(pos_c), de_c, sync_c, first_c, last_c, wrap_c, ph_c};
        act[2] = '{16'(cnt_h), 16'(pos_h), de_h, sync_h, first_h, last_h, wrap_h, ph_h};
        act[3] = '{16'(cnt_v), 16'(pos_v), de_v, sync_v, first_v, last_v, wrap_v, ph_v};
        act[4] = '{16'(cnt_d), 16'(pos_d), de_d, sync_d, first_d, last_d, wrap_d, ph_d};
    end

    function automatic int total_of(input int i);
        return ACT[i] + FP[i] + SL[i] + BP[i];
    endfunction

    // Phase a position falls in, from the interval layout of the period.
    function automatic logic [1:0] phase_of(input int i, input int c);
        if (c < ACT[i])                return 2'd0;
        if (c < ACT[i] + FP[i])        return 2'd1;
        if (c < ACT[i] + FP[i] + SL[i]) return 2'd2;
        return 2'd3;
    endfunction

    function automatic obs_t model(input int i, input int c, input bit en);
        obs_t e;
        bit   in_sync;
        in_sync = (c >= ACT[i] + FP[i]) && (c < ACT[i] + FP[i] + SL[i]);
        e.cnt   = 16'(c);
        e.de    = (c < ACT[i]);
        e.pos   = (c < ACT[i]) ? 16'(c) : 16'd0;
        e.first = (c == 0);
        e.last  = (c == ACT[i] - 1);
        e.sync  = in_sync ? POL[i][0] : ~POL[i][0];
        e.wrap  = (c == total_of(i) - 1) && en;
        e.phase = phase_of(i, c);
        return e;
    endfunction

    task automatic chk(input int i, input string f, input logic [15:0] a, input logic [15:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s.%s at t=%0t: got %0d expected %0d", name[i], f, $time, a, e);
        end
    endtask

    // Stimulus: advance the reference for the edge just taken, pick new inputs, queue expectations.
    initial begin
        obs_set_t es;
        bit       v_step;
        rst_v = '1;
        en_v  = '1;
        for (int i = 0; i < NI; i++) m_cnt[i] = 0;
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge clk);
            #1;
            v_step = (m_cnt[2] == total_of(2) - 1) && en_v[2];
            for (int i = 0; i < NI; i++) begin
                bit step;
                step = (i == 3) ? v_step : en_v[i];
                if (rst_v[i])  m_cnt[i] = 0;
                else if (step) m_cnt[i] = (m_cnt[i] + 1) % total_of(i);
            end

            if (cyc < 3) begin
                rst_v = '1;
                en_v  = 5'b10111;
            end else begin
                // A: continuous, then alternating, then random with mid-sync resets.
                if (cyc < 100)      en_v[0] = 1'b1;
                else if (cyc < 200) en_v[0] = cyc[0];
                else                en_v[0] = ($urandom % 4) != 0;
                rst_v[0] = (cyc >= 200) && (((m_cnt[0] == 5) && ($urandom % 3 == 0)) ||
                                            ($urandom % 64 == 0));
                en_v[1]  = ($urandom % 5) != 0;
                rst_v[1] = ($urandom % 97) == 0;
                en_v[2]  = (cyc < 600) ? 1'b1 : (($urandom % 4) != 0);
                rst_v[2] = (cyc >= 600) && (($urandom % 150) == 0);
                en_v[3]  = 1'b0;
                rst_v[3] = (cyc >= 600) && (($urandom % 200) == 0);
                en_v[4]  = (cyc < 900) ? 1'b1 : (($urandom % 8) != 0);
                rst_v[4] = (cyc >= 900) && (($urandom % 300) == 0);
            end

            v_step = (m_cnt[2] == total_of(2) - 1) && en_v[2];
            for (int i = 0; i < NI; i++)
                es[i] = model(i, m_cnt[i], (i == 3) ? v_step : en_v[i]);
            sbq.push_back(es);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Monitor: pop one expectation per cycle and compare all instances, plus phase/counter agreement.
    initial begin
        obs_set_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                for (int i = 0; i < NI; i++) begin
                    chk(i, "cnt",   act[i].cnt,          e[i].cnt);
                    chk(i, "pos",   act[i].pos,          e[i].pos);
                    chk(i, "de",    16'(act[i].de),      16'(e[i].de));
                    chk(i, "sync",  16'(act[i].sync),    16'(e[i].sync));
                    chk(i, "first", 16'(act[i].first),   16'(e[i].first));
                    chk(i, "last",  16'(act[i].last),    16'(e[i].last));
                    chk(i, "wrap",  16'(act[i].wrap),    16'(e[i].wrap));
                    chk(i, "phase", 16'(act[i].phase),   16'(e[i].phase));
                    checks++;
                    assert (act[i].phase === phase_of(i, int'(act[i].cnt))) else begin
                        errors++;
                        $display("FAIL %s.phase_vs_cnt at t=%0t: got phase %0d at cnt %0d expected %0d",
                                 name[i], $time, act[i].phase, act[i].cnt,
                                 phase_of(i, int'(act[i].cnt)));
                    end
                end
            end
        end
    end

endmodule

// File: doc/sync_timing_gen.md
Name: sync_timing_gen

Overview:
Parametrised one-axis video timing generator, the successor to the fixed-geometry vertical sync counter. It is a single module for either axis. Horizontal mode ties i_en high and counts pixels. Vertical mode drives i_en from the horizontal instance's o_wrap and counts lines. Active length, porches, sync length, sync polarity and counter width are all parameters. It adds an explicit phase state machine, an advance enable, a cascade wrap pulse, active-relative coordinates and start/end markers.

Parameters:
ACTIVE, 272, active (displayed) units per period; must be >= 1
FRONT_PORCH, 4, units after active and before sync; may be 0
SYNC_LEN, 10, sync pulse units; must be >= 1
BACK_PORCH, 4, units after sync and before the next active; may be 0
SYNC_POL, 0, asserted level of o_sync (0 = active-low)
CNT_W, 10, counter width; 2**CNT_W must be >= TOTAL, where TOTAL = ACTIVE + FRONT_PORCH + SYNC_LEN + BACK_PORCH

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_en  in  1  advance strobe; the counter steps only on cycles with i_en=1
o_cnt  out  CNT_W  raw position within the period, 0..TOTAL-1
o_pos  out  CNT_W  active coordinate: equals o_cnt while o_de=1, otherwise 0
o_de  out  1  data enable; high while o_cnt < ACTIVE
o_sync  out  1  sync output at SYNC_POL level during the sync phase, inverse level otherwise
o_first  out  1  high while o_cnt == 0
o_last  out  1  high while o_cnt == ACTIVE-1
o_wrap  out  1  o_cnt == TOTAL-1 and i_en=1; cascade pulse for the next axis
o_phase  out  2  current phase: 0 ACTIVE, 1 FRONT, 2 SYNC, 3 BACK

Behaviour:
- Registered state: counter (CNT_W bits) and 2-bit phase register. All outputs except o_wrap are decoded from registered state only; no input-to-output path.
- Reset (i_rst=1 at a clock edge) gives o_cnt=0, phase ACTIVE, o_de=1, o_pos=0, o_first=1, o_last=(ACTIVE==1), o_sync=~SYNC_POL, o_wrap=0.
- i_rst has priority over i_en. Reset mid-period returns to cnt 0 / ACTIVE on the next edge, with no partial sync carried over.
- Each edge with i_en=1: if cnt == TOTAL-1 then cnt <= 0, else cnt <= cnt+1.
- Each edge with i_en=0: all state holds and outputs are static.
- The phase register advances in step with the counter on these boundaries:
  - ACTIVE->FRONT when the next cnt = ACTIVE
  - FRONT->SYNC when the next cnt = ACTIVE+FRONT_PORCH
  - SYNC->BACK when the next cnt = ACTIVE+FRONT_PORCH+SYNC_LEN
  - BACK->ACTIVE on wrap
- A zero-length porch skips its phase entirely:
  - FRONT_PORCH=0 gives ACTIVE->SYNC
  - BACK_PORCH=0 gives SYNC->ACTIVE on wrap
  - The skipped phase never appears on o_phase, not even for one cycle.
- o_sync equals SYNC_POL exactly when phase==SYNC, for exactly SYNC_LEN advancing steps per period.
- o_wrap is combinational: (cnt==TOTAL-1) & i_en. It is high for one cycle per period when i_en is continuous. If i_en is held low at TOTAL-1, o_wrap stays low.
- Phase and counter must never disagree; the bench checks this continuously with an assertion on o_phase vs o_cnt.
- Width rule: compare constants are sized to CNT_W; no truncation is allowed. Elaboration fails (generate-time error) if TOTAL > 2**CNT_W, ACTIVE=0 or SYNC_LEN=0.
- Cascade contract: vertical.i_en = horizontal.o_wrap. The vertical counter therefore changes on the same edge the horizontal counter returns to 0.

Test Plan:
- ACTIVE=4, FP=1, SYNC=2, BP=1 (TOTAL=8), i_en=1 -> o_cnt sequence 0..7 repeating; o_de high cnt 0-3; o_sync low cnt 5-6; o_wrap high only at cnt 7; o_phase 0,0,0,0,1,2,2,3.
- Same configuration, i_en toggling 1,0,1,0 -> o_cnt advances every other cycle; o_sync low for exactly 2 advancing steps (4 clocks); o_wrap high only on the i_en=1 cycle at cnt 7.
- FP=0, BP=0, ACTIVE=3, SYNC=1 -> o_phase sequence 0,0,0,2 repeating; FRONT and BACK never observed; o_first at cnt 0; o_last at cnt 2.
- Assert i_rst at cnt 5 (mid-sync) -> next edge o_cnt=0, o_sync=1 (SYNC_POL=0), o_de=1, o_first=1; resumes normal count.
- Cascade H (TOTAL=8, i_en=1) into V (ACTIVE=2, FP=0, SYNC=1, BP=1) -> V.o_cnt increments once per 8 clocks on H wrap; V.o_sync asserted for exactly 8 clocks per 32-clock frame.
- Default parameters, SYNC_POL=1 -> o_sync high for cnt 276-285; o_de high for 272 of 290 counts; o_pos=0 for cnt >= 272.
